// File: rtl/drbg_out_buffer.sv
// Block FIFO behind the CTR-DRBG that serves 128-bit random blocks as OUT_W-bit words, MSB first.
// Define DRBG_OUTBUF_ZEROIZE_EN to wipe consumed entries, and all entries on reset or flush.
module drbg_out_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned LOW_WATER = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [127:0]            in_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [OUT_W-1:0]        out_data_o,
  input  logic                    flush_i,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic                    low_water_o,
  output logic [31:0]             words_out_o
);

  localparam int unsigned NumSlices = 128 / OUT_W;
  localparam int unsigned SliceW    = (NumSlices > 1) ? $clog2(NumSlices) : 1;
  localparam int unsigned PtrW      = $clog2(DEPTH);
  localparam int unsigned LvlW      = $clog2(DEPTH) + 1;

  logic [127:0]      mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic [SliceW-1:0] slice_q, slice_d;
  logic [31:0]       words_q, words_d;
  logic              push, pop, pop_last;
  logic [127:0]      head_shifted;

  assign full_o      = (level_q == LvlW'(DEPTH));
  assign empty_o     = (level_q == '0);
  assign low_water_o = (level_q < LvlW'(LOW_WATER));
  assign level_o     = level_q;
  assign words_out_o = words_q;

  // A pop never frees space for a same-cycle push: in_ready_o looks only at stored level.
  assign in_ready_o  = !full_o && !flush_i;
  assign out_valid_o = !empty_o;

  assign push     = in_valid_i && in_ready_o;
  assign pop      = out_valid_o && out_ready_i && !flush_i;
  assign pop_last = pop && (slice_q == SliceW'(NumSlices - 1));

  // Shift the head entry so the current slice lands in the top OUT_W bits.
  assign head_shifted = mem_q[rd_ptr_q] << (32'(slice_q) * OUT_W);
  assign out_data_o   = out_valid_o ? head_shifted[127 -: OUT_W] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    slice_d  = slice_q;
    words_d  = words_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      words_d = words_q + 32'd1;
      if (pop_last) begin
        slice_d  = '0;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        slice_d = slice_q + 1'b1;
      end
    end
    if (push && !pop_last) begin
      level_d = level_q + 1'b1;
    end else if (!push && pop_last) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      slice_q  <= '0;
      words_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      slice_q  <= slice_d;
      words_q  <= words_d;
    end
  end

`ifdef DRBG_OUTBUF_ZEROIZE_EN
  // Head and tail only coincide when empty or full, so wipe and write never hit one entry.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (pop_last) begin
        mem_q[rd_ptr_q] <= '0;
      end
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end
`endif

endmodule

// File: doc/drbg_out_buffer.md
# drbg_out_buffer

Output stage directly downstream of the CTR-DRBG wrapper. Accepts 128-bit random blocks over a ready/valid handshake, stores them in a small block FIFO, and serves them to the consumer (host interface / output pins) as narrower OUT_W-bit words, MSB slice first. It provides fill-level status and a synchronous flush, and can optionally zeroize consumed random data.

## Interface
- DEPTH, 4, number of 128-bit entries; power of two, ≥2
- OUT_W, 32, output word width; one of 8, 16, 32, 64, 128
- LOW_WATER, 1, low_water_o asserts when level_o < LOW_WATER; range 0..DEPTH

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid_i  in  1  block valid from DRBG wrapper (out_valid_o there)
- in_ready_o  out  1  buffer can accept a block this cycle
- in_data_i  in  128  random block
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  consumer accepts word
- out_data_o  out  OUT_W  output word
- flush_i  in  1  synchronous flush; discards all stored data
- level_o  out  $clog2(DEPTH)+1  entries currently held (a partially read entry counts as one)
- empty_o  out  1  level_o == 0
- full_o  out  1  level_o == DEPTH
- low_water_o  out  1  level_o < LOW_WATER
- words_out_o  out  32  total words delivered since reset/flush; wraps modulo 2^32

## Operation
- Storage: DEPTH×128 memory, write pointer, read pointer, level counter, slice index (0..128/OUT_W−1).
- Push: in_valid_i && in_ready_o at a rising edge writes in_data_i at wr_ptr; wr_ptr wraps DEPTH−1→0.
- in_ready_o = !full_o && !flush_i. A pop in the same cycle does NOT free space for a push while full (no bypass).
- Pop: out_valid_o && out_ready_i advances the slice index and increments words_out_o. Popping the last slice frees the entry: slice→0, rd_ptr wraps, level decrements.
- Slice order: slice k = entry[127−k·OUT_W -: OUT_W]; slice 0 is the MSBs.
- out_valid_o = !empty_o; out_data_o = selected slice when valid, else all-zero.
- Simultaneous push and last-slice pop (not full): level unchanged, both pointers advance.
- Flush (highest priority, over reset-free ops): at the edge with flush_i=1, pointers, slice, level and words_out_o clear to 0; any push/pop presented that cycle is discarded and not counted.
- level_o never exceeds DEPTH and never underflows; pushes are blocked by in_ready_o, pops by out_valid_o.

## Timing
- Reset values: in_ready_o=1, out_valid_o=0, out_data_o=0, level_o=0, empty_o=1, full_o=0, low_water_o=(LOW_WATER>0), words_out_o=0.
- Latency: block pushed at edge N → out_valid_o high and slice 0 on out_data_o in cycle after edge N (1 cycle). No combinational path from in_* to out_*.
- out_data_o, out_valid_o and all status outputs derive from registers only (memory read mux allowed); in_ready_o combinationally depends on flush_i only.
- Sustained throughput: one OUT_W word per cycle; one block per 128/OUT_W cycles. With OUT_W=128, one block/cycle while not full.
- Reset mid-operation: all state returns to reset values at the next edge; partially read block lost.

## Configuration
- DRBG_OUTBUF_ZEROIZE_EN defined: memory resets to zero; an entry is overwritten with zero at the edge its last slice is popped; flush and reset zero all entries in that edge. Consumed random data never remains in storage.
- Not defined: memory has no reset and retains stale contents after pop/flush; only pointers/counters clear. Externally visible port behaviour is identical in both builds.

## Test plan
- Reset, then push 128'h00112233_44556677_8899AABB_CCDDEEFF with out_ready_i=1 (OUT_W=32) -> out_valid_o rises next cycle; words 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF on 4 consecutive cycles; words_out_o=4; empty_o=1 after.
- Hold out_ready_i=0, push 5 blocks with in_valid_i held -> 4 accepted, full_o=1, in_ready_o=0, 5th held; after draining one entry (4 pops) 5th accepted next edge.
- Fill to full, pop last slice of head while in_valid_i=1 -> no push that edge; push occurs the following edge; level_o 4→3→4.
- Level=1, push and last-slice pop same edge -> level_o stays 1, pointers wrap correctly across DEPTH−1→0 over 10 iterations, data order preserved.
- Level=3, mid-block (slice 2), assert flush_i with in_valid_i=1 -> next cycle level_o=0, words_out_o=0, out_valid_o=0, pushed block discarded; with DRBG_OUTBUF_ZEROIZE_EN all memory entries read back zero.
- LOW_WATER=2: level 0→1→2→1 -> low_water_o 1,1,0,1; assert rst_n=0 mid-block -> all outputs at reset values next cycle.
